fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencer for the combinational instruction ROM. Owns the program counter, drives the ROM byte address, and captures each 16-bit instruction word with its PC into a 2-entry buffer. The buffer feeds decode through a valid/ready handshake. Also handles branch redirects (flush plus PC reload) and halt detection. Sits between instruction memory and the decode stage of the ASIP pipeline.

## Interface
- ADDR_W, 8, ROM byte-address width
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC loaded at reset and on start
- HALT_WORD, 16'hFFFF, encoding that ends fetching
- clk  in  1  single clock; everything registers on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins fetching from RESET_PC when in IDLE or HALTED
- imem_addr  out  ADDR_W  byte address to instruction memory (word-aligned, step 4)
- imem_rdata  in  INSTR_W  same-cycle combinational ROM data for imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  target byte address; bits [1:0] forced to 0
- instr_valid  out  1  buffer head holds a valid instruction
- instr_ready  in  1  decode accepts head this cycle
- instr  out  INSTR_W  buffer head instruction
- instr_pc  out  ADDR_W  byte address of instr
- halted  out  1  HALTED state indicator

## Operation
- FSM states: IDLE, FETCH, DRAIN, HALTED.
  - IDLE: no fetch. On start, go to FETCH with pc=RESET_PC.
  - FETCH: push {imem_rdata, pc} and set pc+=4 when push is allowed.
    - Push allowed when count<2, or when count==2 and a pop happens the same cycle.
    - If the pushed word == HALT_WORD, push it and go to DRAIN; pc does not advance.
  - DRAIN: no fetch. When the buffer is empty after a pop, go to HALTED.
  - HALTED: halted=1. On start, flush, set pc=RESET_PC, go to FETCH.
- Pop: instr_valid && instr_ready. Entries leave in push order.
- Redirect (any state except IDLE/HALTED): flush all entries, drop any same-cycle push/pop, set pc={redirect_pc[7:2],2'b00}, go to FETCH. Redirect in DRAIN cancels the halt.
- Priority, highest first: rst_n, redirect, start, pop/push.
- start in FETCH/DRAIN is ignored. redirect in IDLE/HALTED is ignored.
- PC arithmetic is ADDR_W-bit modulo: 8'hFC+4 wraps to 8'h00 with no flag.
- imem_addr = pc register, directly.
- instr/instr_pc show the head entry and hold their value while instr_valid && !instr_ready.
- When the buffer is empty, instr/instr_pc hold their last value (don't-care).

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_addr=RESET_PC
  - count=0, instr_valid=0, instr=0, instr_pc=0, halted=0
- Asynchronous reset mid-operation clears the buffer immediately. Fetch resumes only after a new start.
- start sampled at edge E: FETCH from cycle E+1; first instr_valid=1 in cycle E+2.
- redirect sampled at edge R: instr_valid=0 in cycle R+1 (target fetched that cycle); target instruction valid in cycle R+2.
- Steady state with instr_ready held high: one instruction per cycle, no bubbles.
- instr_ready low for N cycles: the buffer fills to 2, then fetch stalls and pc holds.
- HALT_WORD pushed at edge H: halted=1 one cycle after the edge that pops the last entry.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, FETCH, DRAIN, HALTED)
  - PC_STEP=4 and HALT_WORD default
  - fetch_entry_t struct {instr, pc}
- Sub-module fetch_fifo:
  - 2-entry synchronous FIFO of fetch_entry_t
  - ports: push, pop, flush, full, empty, head
  - same-cycle push+pop when full is legal
  - flush has priority over push/pop
- Top level holds the FSM and the pc register only.

## Test plan
- Reset then start with ROM words 0x1111, 0x2222, 0x3333 at 0x00/0x04/0x08 and ready=1 -> instr_valid rises 2 cycles after start; instr sequence 0x1111/0x2222/0x3333 with instr_pc 0x00/0x04/0x08 on consecutive cycles.
- Backpressure: ready=0 for 5 cycles after first valid -> count saturates at 2, imem_addr holds at 0x08. On release, 0x1111 and 0x2222 pop in order with no loss or duplication.
- Redirect to 0x43 while the buffer is full -> next cycle instr_valid=0 and imem_addr=0x40; the following cycle instr_pc=0x40.
- Wrap: redirect to 0xFC -> instr_pc 0xFC then 0x00.
- Halt: HALT_WORD at 0x0C -> entry 0x0C is delivered, no fetch past 0x0C, halted=1 after the last pop.
  - Redirect during DRAIN -> halted stays 0 and fetch restarts at the target.
- rst_n low mid-stream with valid=1 -> outputs go to reset values asynchronously. After release, start refetches from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction fetch controller.
// Rev     : 1.0
//------------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;
  localparam int PC_STEP       = 4;

  localparam logic [FETCH_INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_fifo
// Brief   : Two-entry FIFO of {instr, pc}; flush overrides push/pop.
// Rev     : 1.0
//------------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // push+pop together leaves the occupancy unchanged
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_controller
// Brief   : PC sequencer feeding decode from a combinational ROM via a 2-deep buffer.
// Rev     : 1.0
//------------------------------------------------------------------------------
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = FETCH_ADDR_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_redirect;
  logic              w_flush;
  logic [ADDR_W-1:0] w_redir_pc;
  fetch_entry_t      w_din;
  fetch_entry_t      w_head;

  assign w_pop      = !w_empty && instr_ready;
  assign w_redirect = redirect_valid && ((r_state == FETCH) || (r_state == DRAIN));
  assign w_flush    = w_redirect || (start && (r_state == HALTED));
  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
  // a full buffer can still take a word when decode drains one this cycle
  assign w_push     = (r_state == FETCH) && (!w_full || w_pop) && !w_redirect;
  assign w_din      = '{instr: imem_rdata, pc: r_pc};

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop && !w_redirect),
    .flush (w_flush),
    .din   (w_din),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (w_redirect) begin
      r_state <= FETCH;
      r_pc    <= w_redir_pc;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
          end
        end
        FETCH: begin
          if (w_push) begin
            if (imem_rdata == HALT_WORD) begin
              r_state <= DRAIN;
            end else begin
              r_pc <= r_pc + ADDR_W'(PC_STEP);
            end
          end
        end
        DRAIN: begin
          // popping while not full means the last entry is leaving
          if (w_pop && !w_full) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_fetch_controller
// Brief   : Self-checking bench: vector table, directed corner cases, random vs model.
// Rev     : 1.0
//------------------------------------------------------------------------------
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        halted;

  logic [15:0] rom [64];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr[7:2]];

  fetch_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rom_default();
    for (int i = 0; i < 64; i++) rom[i] = 16'hA000 | 16'(i);
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3333;
  endtask

  task automatic do_reset();
    start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, st, rdy, rv;
    logic [7:0] rpc;
    logic       ev, chkd;
    logic [15:0] ei;
    logic [7:0] ep, ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic st, logic rdy, logic rv, logic [7:0] rpc,
                              logic ev, logic chkd, logic [15:0] ei, logic [7:0] ep, logic [7:0] ea);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.chkd = chkd; v.ei = ei; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] i; logic [7:0] p; } ent_t;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  ent_t       mq[$];
  int         mmode;
  logic [7:0] mpc;

  task automatic model_reset();
    mq.delete(); mmode = M_IDLE; mpc = 8'h00;
  endtask

  // Applies one clock edge of the behavioural rules to the model.
  task automatic model_step();
    bit active = (mmode == M_RUN) || (mmode == M_DRAIN);
    bit popped;
    ent_t e;
    if (redirect_valid && active) begin
      mq.delete(); mpc = redirect_pc & 8'hFC; mmode = M_RUN;
    end else if (start && !active) begin
      mq.delete(); mpc = 8'h00; mmode = M_RUN;
    end else begin
      popped = (mq.size() > 0) && instr_ready;
      if (popped) void'(mq.pop_front());
      if (mmode == M_RUN && mq.size() < 2) begin
        e.i = rom[mpc >> 2]; e.p = mpc;
        mq.push_back(e);
        if (e.i == 16'hFFFF) mmode = M_DRAIN;
        else mpc = mpc + 8'd4;
      end else if (mmode == M_DRAIN && popped && mq.size() == 0) begin
        mmode = M_HALT;
      end
    end
  endtask

  initial begin
    int got, last_v, hcyc;
    logic [7:0] maxaddr;
    logic [15:0] exp_i [4];
    logic [7:0]  exp_p [4];

    rom_default();
    do_reset();

    // ---- table-driven: start, stream, backpressure, redirect, wrap ----
    tbl.push_back(mk(1,0,0,0,8'h00, 0,1,16'h0000,8'h00,8'h00));
    tbl.push_back(mk(0,1,1,0,8'h00, 0,1,16'h0000,8'h00,8'h00));
    tbl.push_back(mk(0,0,1,0,8'h00, 0,1,16'h0000,8'h00,8'h00));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'h1111,8'h00,8'h04));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'h2222,8'h04,8'h08));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'h3333,8'h08,8'h0C));
    tbl.push_back(mk(1,0,0,0,8'h00, 0,1,16'h0000,8'h00,8'h00));
    tbl.push_back(mk(0,1,0,0,8'h00, 0,1,16'h0000,8'h00,8'h00));
    tbl.push_back(mk(0,0,0,0,8'h00, 0,1,16'h0000,8'h00,8'h00));
    tbl.push_back(mk(0,0,0,0,8'h00, 1,1,16'h1111,8'h00,8'h04));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,0,0,8'h00, 1,1,16'h1111,8'h00,8'h08));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'h1111,8'h00,8'h08));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'h2222,8'h04,8'h0C));
    tbl.push_back(mk(0,0,0,0,8'h00, 1,1,16'h3333,8'h08,8'h10));
    tbl.push_back(mk(0,0,0,1,8'h43, 1,1,16'h3333,8'h08,8'h10));
    tbl.push_back(mk(0,0,1,0,8'h00, 0,0,16'h0000,8'h00,8'h40));
    tbl.push_back(mk(0,0,1,1,8'hFC, 1,1,16'hA010,8'h40,8'h44));
    tbl.push_back(mk(0,0,1,0,8'h00, 0,0,16'h0000,8'h00,8'hFC));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'hA03F,8'hFC,8'h00));
    tbl.push_back(mk(0,0,1,0,8'h00, 1,1,16'h1111,8'h00,8'h04));

    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk); #1;
      rst_n = !tbl[r].rst; start = tbl[r].st; instr_ready = tbl[r].rdy;
      redirect_valid = tbl[r].rv; redirect_pc = tbl[r].rpc;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), 32'(instr_valid), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_addr", r), 32'(imem_addr), 32'(tbl[r].ea));
      chk($sformatf("tbl%0d_halted", r), 32'(halted), 32'd0);
      if (tbl[r].chkd) begin
        chk($sformatf("tbl%0d_instr", r), 32'(instr), 32'(tbl[r].ei));
        chk($sformatf("tbl%0d_pc", r), 32'(instr_pc), 32'(tbl[r].ep));
      end
    end

    // ---- halt: word at 0x0C ends fetching, halted one cycle after last pop ----
    rom[3] = 16'hFFFF;
    exp_i[0] = 16'h1111; exp_i[1] = 16'h2222; exp_i[2] = 16'h3333; exp_i[3] = 16'hFFFF;
    exp_p[0] = 8'h00;    exp_p[1] = 8'h04;    exp_p[2] = 8'h08;    exp_p[3] = 8'h0C;
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    got = 0; last_v = -10; hcyc = -1; maxaddr = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (halted) begin hcyc = c; break; end
      if (imem_addr > maxaddr) maxaddr = imem_addr;
      if (instr_valid) begin
        if (got < 4) begin
          chk($sformatf("halt_instr%0d", got), 32'(instr), 32'(exp_i[got]));
          chk($sformatf("halt_pc%0d", got), 32'(instr_pc), 32'(exp_p[got]));
        end
        got++; last_v = c;
      end
      @(posedge clk); #1;
    end
    chk("halt_count", 32'(got), 32'd4);
    chk("halt_maxaddr", 32'(maxaddr), 32'h0C);
    chk("halt_latency", 32'(hcyc - last_v), 32'd1);
    chk("halt_valid_low", 32'(instr_valid), 32'd0);

    // ---- redirect during drain cancels the halt ----
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_valid && instr == 16'h3333) begin got = 1; break; end
    end
    chk("drain_reach", 32'(got), 32'd1);
    @(posedge clk); #1 instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h22;
    @(negedge clk);
    chk("drain_head", 32'(instr), 32'hFFFF);
    @(posedge clk); #1 redirect_valid = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("drain_redir_valid", 32'(instr_valid), 32'd0);
    chk("drain_redir_addr", 32'(imem_addr), 32'h20);
    chk("drain_redir_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_tgt_instr", 32'(instr), 32'hA008);
    chk("drain_tgt_pc", 32'(instr_pc), 32'h20);
    repeat (4) begin
      @(negedge clk);
      chk("drain_no_halt", 32'(halted), 32'd0);
    end

    // ---- asynchronous reset mid-stream ----
    rom[3] = 16'hA003;
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("arst_pre_valid", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instr), 32'd0);
    chk("arst_pc", 32'(instr_pc), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_idle_valid", 32'(instr_valid), 32'd0);
      chk("arst_idle_addr", 32'(imem_addr), 32'd0);
    end
    pulse_start();
    @(negedge clk);
    chk("arst_e1_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_e2_valid", 32'(instr_valid), 32'd1);
    chk("arst_e2_instr", 32'(instr), 32'h1111);
    chk("arst_e2_pc", 32'(instr_pc), 32'h00);

    // ---- randomized run against the behavioural model ----
    for (int i = 0; i < 64; i++)
      rom[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start          = ($urandom_range(0, 15) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom);
      @(negedge clk);
      chk("rnd_valid", 32'(instr_valid), 32'(mq.size() > 0));
      chk("rnd_addr", 32'(imem_addr), 32'(mpc));
      chk("rnd_halted", 32'(halted), 32'(mmode == M_HALT));
      if (mq.size() > 0) begin
        chk("rnd_instr", 32'(instr), 32'(mq[0].i));
        chk("rnd_pc", 32'(instr_pc), 32'(mq[0].p));
      end
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
